spi_mem_arbiter: RTL and testbench
==================================

# spi_mem_arbiter

Shares the single external SPI RAM between the cora16 core's two memory requesters, instruction fetch and data load/store, and sequences each access as a complete SPI READ/WRITE frame. It sits between the core and the `spi_select`/`spi_clk`/`spi_mosi`/`spi_miso` pins. It drives the `busy` status pin. Ties between requesters are resolved round-robin so neither requester starves.

## Interface
- `ADDR_W`, default 16: word-address width, at most 23. Byte address = `{zero-extend, addr, 1'b0}` to 24 bits.
- `clk` input 1: single clock.
- `rst_n` input 1: reset, asynchronous, active-low.
- `f_req` input 1: fetch request, read only; level, held until `f_done`.
- `f_addr` input ADDR_W: fetch word address.
- `f_done` output 1: one-cycle completion pulse for fetch.
- `d_req` input 1: data request; level, held until `d_done`.
- `d_we` input 1: 1 = write, 0 = read.
- `d_addr` input ADDR_W: data word address.
- `d_wdata` input 16: write data.
- `d_done` output 1: one-cycle completion pulse for data.
- `rdata` output 16: read result; valid in the `*_done` cycle of a read, held until the next read completes.
- `busy` output 1: high whenever state is not IDLE.
- `spi_select` output 1: RAM chip select, active-high.
- `spi_clk` output 1: SPI clock, mode 0.
- `spi_mosi` output 1: serial data to the RAM.
- `spi_miso` input 1: serial data from the RAM.

## Operation
- States: IDLE → SHIFT → DONE → IDLE.
- **IDLE**
  - If neither request is high, stay.
  - If exactly one is high, grant it.
  - If both are high, grant the requester not served last. The `last` flag resets to "data", so fetch wins the first tie.
  - On grant, latch the owner, the 48-bit frame, and `we`, then enter SHIFT.
- **Frame**, sent MSB-first:
  - 8-bit command: READ 8'h03 or WRITE 8'h02.
  - 24-bit byte address.
  - 16 data bits, big-endian: [15:8] at byte 2n, [7:0] at 2n+1.
  - For reads, the data bits on mosi are 0.
- **SHIFT**, 48 bits × 2 cycles = 96 cycles:
  - Each bit has a low phase (`spi_clk`=0, mosi updated) then a high phase (`spi_clk`=1).
  - `spi_miso` is sampled at the clk edge ending the high phase.
  - The last 16 samples form `rdata` for reads. For writes, miso is ignored and `rdata` holds.
- **DONE**, 1 cycle:
  - `spi_select`=0 and `spi_clk`=0.
  - The owner's `*_done`=1.
  - `last` ← owner.
  - Next state is IDLE.
- Request inputs are latched only at grant. Changes to `addr`/`wdata`/`we` or a dropped `req` mid-frame do not affect or abort the frame.
- A requester must sample its `req` low at the edge ending its DONE cycle. Otherwise it is re-granted in the following IDLE.

## Timing
- Cycle 0: IDLE with `req` high.
- Cycles 1–96: SHIFT. `spi_select`=1 and `busy`=1 throughout.
- Cycle 97: DONE, with the `*_done` pulse.
- Cycle 98: IDLE. The earliest next grant takes effect at the edge ending cycle 98.
- Request-to-done latency is 97 cycles. Back-to-back frames have a 2-cycle deselect gap (cycles 97 and 98).
- All outputs are registered: no combinational path from inputs to the SPI pins or the done pulses.
- Reset values (`rst_n` low, asynchronous, including mid-frame):
  - `spi_select`=0, `spi_clk`=0, `spi_mosi`=0.
  - `f_done`=0, `d_done`=0, `busy`=0.
  - `rdata`=16'h0000, state=IDLE, `last`=data.
- An aborted frame produces no done pulse. After reset deasserts, arbitration restarts in IDLE.

## Structure
- Package `cora16_spi_pkg` holds:
  - `CMD_READ` and `CMD_WRITE`.
  - `FRAME_BITS`=48 and `DATA_BITS`=16.
  - The state enum {IDLE, SHIFT, DONE}.
  - The owner encoding {OWN_FETCH, OWN_DATA}.
- Sub-module `spi_shift_engine` contains:
  - the 48-bit shift register, 6-bit bit counter and phase flag;
  - the miso capture;
  - `start`/`finished` handshake toward the arbiter FSM.
- The arbiter keeps the FSM, the grant logic, `last`, and done routing.

## Test plan
- Fetch read: memory word 0x0010 = 16'hBEEF; `f_req` with `f_addr`=0x0010. Required:
  - mosi carries 8'h03 then 24'h000020;
  - `f_done` in cycle 97;
  - `rdata`=16'hBEEF;
  - `d_done` stays 0.
- Data write then read: `d_we`=1, `d_addr`=0x0100, `d_wdata`=16'h1234. Required:
  - mosi carries 02 000200 1234;
  - a following read of 0x0100 returns 16'h1234;
  - the debug port shows byte 0x200=12 and 0x201=34.
- Simultaneous requests after reset: `f_req` and `d_req` both high at cycle 0. Required:
  - fetch is served first (`f_done` at 97);
  - data is served next (`d_done` at 195);
  - on a second tie the order alternates.
- Starvation: `d_req` held continuously with repeated writes and `f_req` high. Required: fetch is served every other frame.
- Mid-frame change: `d_addr` changed and `d_req` dropped at cycle 40. Required: the frame completes with the latched address and `d_done` still pulses at 97.
- Reset mid-frame: `rst_n` low at cycle 50. Required:
  - `spi_select`, `spi_clk` and `busy` go to 0 immediately;
  - no done pulse;
  - after release, a new request completes normally in 97 cycles.

Source files
------------

// File: rtl/cora16_spi_pkg.sv
// rtl/cora16_spi_pkg.sv - shared constants and types for the cora16 SPI RAM arbiter
// Holds the SPI command bytes, frame geometry, the arbiter state enum,
// the requester (owner) encoding and a helper that builds a 48-bit frame.
package cora16_spi_pkg;

    localparam logic [7:0] CMD_READ   = 8'h03;
    localparam logic [7:0] CMD_WRITE  = 8'h02;
    localparam int         FRAME_BITS = 48;
    localparam int         DATA_BITS  = 16;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    typedef enum logic {
        OWN_FETCH,
        OWN_DATA
    } owner_t;

    // Command, 24-bit byte address, then 16 data bits (zero for reads).
    function automatic logic [FRAME_BITS-1:0] build_frame(
        input logic                 we,
        input logic [23:0]          baddr,
        input logic [DATA_BITS-1:0] wdata
    );
        return {(we ? CMD_WRITE : CMD_READ), baddr, (we ? wdata : {DATA_BITS{1'b0}})};
    endfunction

endpackage

// File: rtl/spi_mem_arbiter_engine.sv
// rtl/spi_mem_arbiter_engine.sv - SPI mode-0 frame shifter for the RAM arbiter
// Module spi_shift_engine.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   i_start            load i_frame / i_we and begin a 48-bit frame
//   i_frame, i_we      frame to send (MSB first), 1 = write (miso ignored)
//   i_miso             serial data from the RAM
//   o_finished         high on the cycle whose ending edge completes the frame
//   o_sel/o_sclk/o_mosi registered SPI pins
//   o_rdata            last 16 miso samples of a read frame, held otherwise
module spi_shift_engine
    import cora16_spi_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_start,
    input  logic [FRAME_BITS-1:0] i_frame,
    input  logic                  i_we,
    input  logic                  i_miso,
    output logic                  o_finished,
    output logic                  o_sel,
    output logic                  o_sclk,
    output logic                  o_mosi,
    output logic [DATA_BITS-1:0]  o_rdata
);

    logic                  r_active;
    logic                  r_phase;     // 0 = low phase, 1 = high phase
    logic [5:0]            r_cnt;
    logic [FRAME_BITS-1:0] r_sreg;      // bits still to send, next one at MSB
    logic [DATA_BITS-1:0]  r_rx;
    logic                  r_we;
    logic                  r_sel;
    logic                  r_sclk;
    logic                  r_mosi;
    logic [DATA_BITS-1:0]  r_rdata;
    logic                  w_last;

    assign w_last     = r_active && r_phase && (r_cnt == 6'(FRAME_BITS - 1));
    assign o_finished = w_last;
    assign o_sel      = r_sel;
    assign o_sclk     = r_sclk;
    assign o_mosi     = r_mosi;
    assign o_rdata    = r_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active <= 1'b0;
            r_phase  <= 1'b0;
            r_cnt    <= 6'd0;
            r_sreg   <= '0;
            r_rx     <= '0;
            r_we     <= 1'b0;
            r_sel    <= 1'b0;
            r_sclk   <= 1'b0;
            r_mosi   <= 1'b0;
            r_rdata  <= '0;
        end else if (i_start) begin
            // First bit goes straight onto mosi so cycle 1 is its low phase.
            r_active <= 1'b1;
            r_phase  <= 1'b0;
            r_cnt    <= 6'd0;
            r_sreg   <= {i_frame[FRAME_BITS-2:0], 1'b0};
            r_mosi   <= i_frame[FRAME_BITS-1];
            r_we     <= i_we;
            r_sel    <= 1'b1;
            r_sclk   <= 1'b0;
        end else if (r_active) begin
            if (!r_phase) begin
                r_phase <= 1'b1;
                r_sclk  <= 1'b1;
            end else begin
                // Edge ending the high phase: capture miso, drop sclk.
                r_rx    <= {r_rx[DATA_BITS-2:0], i_miso};
                r_phase <= 1'b0;
                r_sclk  <= 1'b0;
                if (w_last) begin
                    r_active <= 1'b0;
                    r_sel    <= 1'b0;
                    r_mosi   <= 1'b0;
                    if (!r_we) begin
                        r_rdata <= {r_rx[DATA_BITS-2:0], i_miso};
                    end
                end else begin
                    r_cnt  <= r_cnt + 6'd1;
                    r_mosi <= r_sreg[FRAME_BITS-1];
                    r_sreg <= {r_sreg[FRAME_BITS-2:0], 1'b0};
                end
            end
        end
    end

endmodule

// File: rtl/spi_mem_arbiter.sv
// rtl/spi_mem_arbiter.sv - round-robin arbiter sharing one SPI RAM between fetch and data
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   f_req, f_addr, f_done            fetch requester (read only)
//   d_req, d_we, d_addr, d_wdata,
//   d_done                           data requester (read or write)
//   rdata                            read result, valid in the done cycle, held
//   busy                             high whenever the arbiter is not idle
//   spi_select/spi_clk/spi_mosi/
//   spi_miso                         SPI RAM pins (mode 0, select active-high)
module spi_mem_arbiter
    import cora16_spi_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 f_req,
    input  logic [ADDR_W-1:0]    f_addr,
    output logic                 f_done,
    input  logic                 d_req,
    input  logic                 d_we,
    input  logic [ADDR_W-1:0]    d_addr,
    input  logic [DATA_BITS-1:0] d_wdata,
    output logic                 d_done,
    output logic [DATA_BITS-1:0] rdata,
    output logic                 busy,
    output logic                 spi_select,
    output logic                 spi_clk,
    output logic                 spi_mosi,
    input  logic                 spi_miso
);

    state_t                r_state;
    state_t                w_next;
    owner_t                r_owner;
    owner_t                r_last;
    owner_t                w_owner;
    logic                  r_f_done;
    logic                  r_d_done;
    logic                  w_start;
    logic                  w_we;
    logic                  w_finished;
    logic [FRAME_BITS-1:0] w_frame;
    logic [23:0]           w_f_baddr;
    logic [23:0]           w_d_baddr;

    // Word address to byte address: zero-extend, then append a 0 LSB.
    assign w_f_baddr = 24'(f_addr) << 1;
    assign w_d_baddr = 24'(d_addr) << 1;

    assign f_done = r_f_done;
    assign d_done = r_d_done;
    assign busy   = (r_state != IDLE);

    always_comb begin
        w_next  = r_state;
        w_start = 1'b0;
        w_owner = r_owner;
        w_we    = 1'b0;
        w_frame = '0;
        case (r_state)
            IDLE: begin
                // Fetch wins a tie only if data was served last.
                if (f_req && (!d_req || r_last == OWN_DATA)) begin
                    w_start = 1'b1;
                    w_owner = OWN_FETCH;
                    w_frame = build_frame(1'b0, w_f_baddr, '0);
                    w_next  = SHIFT;
                end else if (d_req) begin
                    w_start = 1'b1;
                    w_owner = OWN_DATA;
                    w_we    = d_we;
                    w_frame = build_frame(d_we, w_d_baddr, d_wdata);
                    w_next  = SHIFT;
                end
            end
            SHIFT: begin
                if (w_finished) begin
                    w_next = DONE;
                end
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_owner  <= OWN_FETCH;
            r_last   <= OWN_DATA;
            r_f_done <= 1'b0;
            r_d_done <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_owner  <= w_owner;
            r_f_done <= w_finished && (r_owner == OWN_FETCH);
            r_d_done <= w_finished && (r_owner == OWN_DATA);
            if (r_state == DONE) begin
                r_last <= r_owner;
            end
        end
    end

    spi_shift_engine u_engine (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_start    (w_start),
        .i_frame    (w_frame),
        .i_we       (w_we),
        .i_miso     (spi_miso),
        .o_finished (w_finished),
        .o_sel      (spi_select),
        .o_sclk     (spi_clk),
        .o_mosi     (spi_mosi),
        .o_rdata    (rdata)
    );

endmodule

// File: tb/tb_spi_mem_arbiter.sv
// tb/tb_spi_mem_arbiter.sv - directed self-checking bench for spi_mem_arbiter
module tb_spi_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        f_req = 1'b0;
    logic [15:0] f_addr = '0;
    logic        f_done;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [15:0] d_addr = '0;
    logic [15:0] d_wdata = '0;
    logic        d_done;
    logic [15:0] rdata;
    logic        busy;
    logic        spi_select;
    logic        spi_clk;
    logic        spi_mosi;
    logic        spi_miso = 1'b0;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int f_cnt = 0;
    int d_cnt = 0;

    spi_mem_arbiter #(.ADDR_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .f_req      (f_req),
        .f_addr     (f_addr),
        .f_done     (f_done),
        .d_req      (d_req),
        .d_we       (d_we),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_done     (d_done),
        .rdata      (rdata),
        .busy       (busy),
        .spi_select (spi_select),
        .spi_clk    (spi_clk),
        .spi_mosi   (spi_mosi),
        .spi_miso   (spi_miso)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (f_done) f_cnt++;
        if (d_done) d_cnt++;
    end

    // SPI RAM model: 4 KiB byte array, READ 03 / WRITE 02, mode 0.
    logic [7:0]  mem [0:4095];
    logic [47:0] m_sh;
    int          m_n = 0;
    logic [7:0]  m_cmd;
    logic [23:0] m_addr;
    logic [15:0] m_rd;
    logic [47:0] frames [$];

    always @(posedge spi_select) begin
        m_n = 0;
        spi_miso = 1'b0;
    end

    always @(posedge spi_clk) begin
        m_sh = {m_sh[46:0], spi_mosi};
        m_n++;
        if (m_n == 32) begin
            m_cmd  = m_sh[31:24];
            m_addr = m_sh[23:0];
            m_rd   = {mem[m_addr[11:0]], mem[m_addr[11:0] + 12'd1]};
        end
        if (m_n > 32 && m_cmd == 8'h03) spi_miso = m_rd[48 - m_n];
        if (m_n == 48) begin
            frames.push_back(m_sh);
            if (m_cmd == 8'h02) begin
                mem[m_addr[11:0]]         = m_sh[15:8];
                mem[m_addr[11:0] + 12'd1] = m_sh[7:0];
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic wait_done(output int who, output int at);
        logic found;
        found = 1'b0;
        who = -1;
        at = -1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (f_done || d_done) begin
                who = f_done ? 0 : 1;
                at = cyc;
                found = 1'b1;
                break;
            end
        end
        check("done_seen", found, 1'b1);
    endtask

    task automatic check_frame(input string tag, input logic [47:0] exp);
        check({tag, "_nframes"}, frames.size(), 1);
        if (frames.size() > 0) check(tag, frames.pop_front(), exp);
        frames.delete();
    endtask

    // One request from one requester; req is dropped inside its DONE cycle.
    task automatic run_one(input bit is_data, input bit we, input logic [15:0] addr,
                           input logic [15:0] wdata, output int lat, output int who);
        int t0;
        int at;
        @(posedge clk); #1;
        t0 = cyc;
        if (is_data) begin
            d_we = we; d_addr = addr; d_wdata = wdata; d_req = 1'b1;
        end else begin
            f_addr = addr; f_req = 1'b1;
        end
        wait_done(who, at);
        f_req = 1'b0;
        d_req = 1'b0;
        lat = at - t0;
        @(negedge clk);
    endtask

    int t0, who, at, lat, prev_at, fc, dc;

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        mem[12'h020] = 8'hBE;
        mem[12'h021] = 8'hEF;

        repeat (3) @(posedge clk); #1;
        check("rst_sel", spi_select, 1'b0);
        check("rst_sclk", spi_clk, 1'b0);
        check("rst_mosi", spi_mosi, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_fdone", f_done, 1'b0);
        check("rst_ddone", d_done, 1'b0);
        check("rst_rdata", rdata, 16'h0000);
        rst_n = 1'b1;

        // Fetch read of word 0x0010 with per-cycle timing checks.
        @(posedge clk); #1;
        t0 = cyc; dc = d_cnt;
        f_addr = 16'h0010; f_req = 1'b1;
        for (int k = 0; k <= 98; k++) begin
            @(negedge clk);
            if (k == 1) begin
                check("t1_sel_c1", spi_select, 1'b1);
                check("t1_busy_c1", busy, 1'b1);
            end
            if (k == 96) check("t1_sel_c96", spi_select, 1'b1);
            if (k == 97) begin
                check("t1_fdone_c97", f_done, 1'b1);
                check("t1_sel_c97", spi_select, 1'b0);
                check("t1_sclk_c97", spi_clk, 1'b0);
                check("t1_busy_c97", busy, 1'b1);
                check("t1_rdata", rdata, 16'hBEEF);
                f_req = 1'b0;
            end
            if (k == 98) begin
                check("t1_busy_c98", busy, 1'b0);
                check("t1_fdone_c98", f_done, 1'b0);
            end
        end
        check_frame("t1_frame", 48'h03_000020_0000);
        check("t1_no_ddone", d_cnt, dc);

        // Data write then read back.
        run_one(1, 1, 16'h0100, 16'h1234, lat, who);
        check("t2_who", who, 1);
        check("t2_lat", lat, 97);
        check_frame("t2_frame", 48'h02_000200_1234);
        check("t2_mem200", mem[12'h200], 8'h12);
        check("t2_mem201", mem[12'h201], 8'h34);
        check("t2_rdata_hold", rdata, 16'hBEEF);
        run_one(1, 0, 16'h0100, 16'h0000, lat, who);
        check("t2_rd_lat", lat, 97);
        check("t2_rd_rdata", rdata, 16'h1234);
        check_frame("t2_rd_frame", 48'h03_000200_0000);

        // Tie right after reset: fetch first, then data.
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        t0 = cyc;
        f_addr = 16'h0010; d_addr = 16'h0100; d_we = 1'b0;
        f_req = 1'b1; d_req = 1'b1;
        wait_done(who, at);
        f_req = 1'b0;
        check("t3_first_who", who, 0);
        check("t3_first_at", at - t0, 97);
        check("t3_first_rdata", rdata, 16'hBEEF);
        wait_done(who, at);
        d_req = 1'b0;
        check("t3_second_who", who, 1);
        check("t3_second_at", at - t0, 195);
        check("t3_second_rdata", rdata, 16'h1234);
        frames.delete();
        // Fetch alone leaves last=fetch, so the next tie goes to data.
        run_one(0, 0, 16'h0010, 16'h0000, lat, who);
        @(posedge clk); #1;
        t0 = cyc;
        f_req = 1'b1; d_req = 1'b1;
        wait_done(who, at);
        d_req = 1'b0;
        check("t3_tie2_first_who", who, 1);
        check("t3_tie2_first_at", at - t0, 97);
        wait_done(who, at);
        f_req = 1'b0;
        check("t3_tie2_second_who", who, 0);
        check("t3_tie2_second_at", at - t0, 195);
        @(negedge clk);

        // Both held: grants alternate, data first since fetch was last.
        @(posedge clk); #1;
        d_we = 1'b1; d_addr = 16'h0180; d_wdata = 16'h5555;
        f_req = 1'b1; d_req = 1'b1;
        prev_at = -1;
        for (int i = 0; i < 6; i++) begin
            wait_done(who, at);
            check($sformatf("t4_who_%0d", i), who, (i % 2 == 0) ? 1 : 0);
            if (i > 0) check($sformatf("t4_gap_%0d", i), at - prev_at, 98);
            prev_at = at;
        end
        f_req = 1'b0; d_req = 1'b0;
        @(negedge clk);
        frames.delete();

        // Mid-frame change of inputs and dropped req.
        @(posedge clk); #1;
        t0 = cyc;
        d_we = 1'b1; d_addr = 16'h0300; d_wdata = 16'hA55A; d_req = 1'b1;
        repeat (40) @(posedge clk); #1;
        d_addr = 16'h07FF; d_wdata = 16'h0000; d_we = 1'b0; d_req = 1'b0;
        wait_done(who, at);
        check("t5_who", who, 1);
        check("t5_at", at - t0, 97);
        check_frame("t5_frame", 48'h02_000600_A55A);
        check("t5_mem600", mem[12'h600], 8'hA5);
        check("t5_mem601", mem[12'h601], 8'h5A);
        repeat (2) @(negedge clk);
        check("t5_idle_busy", busy, 1'b0);

        // Reset in the middle of a fetch frame.
        @(posedge clk); #1;
        t0 = cyc;
        f_addr = 16'h0010; f_req = 1'b1;
        repeat (50) @(posedge clk); #1;
        fc = f_cnt; dc = d_cnt;
        check("t6_sclk_before", spi_clk, 1'b1);
        rst_n = 1'b0;
        #1;
        check("t6_sel_rst", spi_select, 1'b0);
        check("t6_sclk_rst", spi_clk, 1'b0);
        check("t6_busy_rst", busy, 1'b0);
        check("t6_mosi_rst", spi_mosi, 1'b0);
        f_req = 1'b0;
        repeat (3) @(posedge clk); #1 rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("t6_no_fdone", f_cnt, fc);
        check("t6_no_ddone", d_cnt, dc);
        frames.delete();
        run_one(0, 0, 16'h0010, 16'h0000, lat, who);
        check("t6_after_who", who, 0);
        check("t6_after_lat", lat, 97);
        check("t6_after_rdata", rdata, 16'hBEEF);
        check_frame("t6_after_frame", 48'h03_000020_0000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
